// File: rtl/router_input_stage_pkg.sv
// -----------------------------------------------------------------------------
// router_input_stage_pkg
// Shared router definitions.
//   - Mesh and stream field widths.
//   - AXI-Stream mosi/miso structs.
//   - The routing-header TID marker.
//   - Header field offsets.
//   - The ingress route FSM encoding.
//   - A helper that decodes a header beat into a destination.
// -----------------------------------------------------------------------------
package router_input_stage_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ID_WIDTH   = 4;
   localparam int DEST_WIDTH = 4;
   localparam int USER_WIDTH = 4;

   localparam int MAX_ROUTERS_X       = 4;
   localparam int MAX_ROUTERS_Y       = 4;
   localparam int MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X);
   localparam int MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y);

   // TID value that marks the first beat of every packet.
   localparam logic [ID_WIDTH-1:0] ROUTING_HEADER = {ID_WIDTH{1'b1}};

   // X sits in the low TDATA bits, and Y sits directly above it.
   localparam int HDR_X_LSB = 0;
   localparam int HDR_Y_LSB = HDR_X_LSB + MAX_ROUTERS_X_WIDTH;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] TDATA;
      logic                  TLAST;
      logic [ID_WIDTH-1:0]   TID;
      logic [DEST_WIDTH-1:0] TDEST;
      logic [USER_WIDTH-1:0] TUSER;
   } axis_data_t;

   typedef struct packed {
      logic       TVALID;
      axis_data_t data;
   } axis_mosi_t;

   typedef struct packed {
      logic TREADY;
   } axis_miso_t;

   typedef enum logic {
      IDLE,
      PACKET
   } route_state_e;

   typedef struct packed {
      logic [MAX_ROUTERS_X_WIDTH-1:0] x;
      logic [MAX_ROUTERS_Y_WIDTH-1:0] y;
   } route_t;

   function automatic route_t decode_route(input axis_data_t beat);
      route_t r;
      r.x = beat.TDATA[HDR_X_LSB +: MAX_ROUTERS_X_WIDTH];
      r.y = beat.TDATA[HDR_Y_LSB +: MAX_ROUTERS_Y_WIDTH];
      return r;
   endfunction

endpackage

// File: rtl/router_input_stage_fifo.sv
// -----------------------------------------------------------------------------
// axis_fifo
// Generic synchronous FIFO. The entry type and the depth are parameters.
// Pointers carry an extra wrap bit, so full and empty can be told apart
// without a separate counter. The head entry is read combinationally.
// Ports:
//   i_clk, i_rst   clock and synchronous active-high reset
//   i_push, i_data write request and its entry (ignored while full)
//   i_pop          read request (ignored while empty)
//   o_data         current head entry
//   o_full         all entries occupied
//   o_empty        no entries occupied
// -----------------------------------------------------------------------------
module axis_fifo #(
   parameter type T     = logic [7:0],
   parameter int  DEPTH = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_push,
   input  T     i_data,
   input  logic i_pop,
   output T     o_data,
   output logic o_full,
   output logic o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   T            r_mem [DEPTH];
   logic        w_push;
   logic        w_pop;

   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   // NOTE: state is updated with <= so that every register samples the
   // pre-edge values, independent of the order of the statements.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // NOTE: the storage array has no reset. The pointers alone define
   // which entries are valid, and a reset on the array would stop it
   // from mapping onto RAM.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/router_input_stage.sv
// -----------------------------------------------------------------------------
// router_input_stage
// Per-port ingress stage of the mesh router. Incoming flits are buffered,
// and the routing header of each packet is decoded. Each buffered beat is
// presented to the channel selector, together with the destination that
// applies to it. The destination is held for the whole packet, up to TLAST.
// A beat that arrives where a header is expected is dropped, and
// hdr_err_o pulses for that beat.
// Ports:
//   clk_i, rst_i  clock and synchronous active-high reset
//   in_mosi_i     incoming flit (TVALID + payload)
//   in_miso_o     TREADY back to the sender (= FIFO not full)
//   out_mosi_o    head beat towards the channel selector
//   out_miso_i    TREADY from the channel selector
//   target_x_o    destination X for the beat on out_mosi_o
//   target_y_o    destination Y for the beat on out_mosi_o
//   hdr_err_o     one-cycle pulse while a stray beat is dropped
// -----------------------------------------------------------------------------
module router_input_stage
   import router_input_stage_pkg::*;
#(
   parameter int BUFFER_DEPTH = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  axis_mosi_t                     in_mosi_i,
   output axis_miso_t                     in_miso_o,
   output axis_mosi_t                     out_mosi_o,
   input  axis_miso_t                     out_miso_i,
   output logic [MAX_ROUTERS_X_WIDTH-1:0] target_x_o,
   output logic [MAX_ROUTERS_Y_WIDTH-1:0] target_y_o,
   output logic                           hdr_err_o
);

   route_state_e r_state;
   route_state_e w_state_next;
   route_t       r_route_q;
   route_t       w_route_hdr;
   route_t       w_target;
   axis_data_t   w_head;
   logic         w_full;
   logic         w_empty;
   logic         w_push;
   logic         w_pop;
   logic         w_drop;
   logic         w_out_valid;
   logic         w_is_hdr;

   assign w_push = in_mosi_i.TVALID && !w_full;

   axis_fifo #(
      .T     (axis_data_t),
      .DEPTH (BUFFER_DEPTH)
   ) u_fifo (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_push  (w_push),
      .i_data  (in_mosi_i.data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_is_hdr    = (w_head.TID == ROUTING_HEADER);
   assign w_route_hdr = decode_route(w_head);

   // NOTE: every signal driven here gets a default first. This keeps all
   // paths assigned, so no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      w_out_valid  = !w_empty;
      w_drop       = 1'b0;
      w_target     = r_route_q;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               if (w_is_hdr) begin
                  // The header steers itself. Its destination is not
                  // yet in route_q.
                  w_target = w_route_hdr;
                  if (out_miso_i.TREADY && !w_head.TLAST) w_state_next = PACKET;
               end else begin
                  // The beat is not part of any packet. Hide it from the
                  // selector and discard it without waiting for TREADY.
                  w_out_valid = 1'b0;
                  w_drop      = 1'b1;
               end
            end
         end
         PACKET: begin
            if (w_out_valid && out_miso_i.TREADY && w_head.TLAST) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign w_pop = (w_out_valid && out_miso_i.TREADY) || w_drop;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_route_q <= '0;
      end else begin
         r_state <= w_state_next;
         // A pop in IDLE that is not a drop is an accepted header.
         if (r_state == IDLE && w_pop && !w_drop) r_route_q <= w_route_hdr;
      end
   end

   assign in_miso_o.TREADY = !w_full;

   // The payload reads as zero whenever the buffer is empty. This keeps
   // uninitialised storage off the output after reset.
   always_comb begin
      out_mosi_o        = '0;
      out_mosi_o.TVALID = w_out_valid;
      if (!w_empty) out_mosi_o.data = w_head;
   end

   assign target_x_o = w_target.x;
   assign target_y_o = w_target.y;
   assign hdr_err_o  = w_drop;

endmodule

// File: tb/tb_router_input_stage.sv
// -----------------------------------------------------------------------------
// tb_router_input_stage
// Directed and randomised stimulus for router_input_stage.
// The reference is a packet-level parse of the sent stream. Each accepted
// beat is classified when it is pushed, from its position in the stream:
//   - a header starts a packet and sets the route,
//   - any beat inside a packet is forwarded with that packet's route,
//   - a non-header beat outside a packet is dropped.
// The classified beats form the expected egress sequence. Buffer occupancy
// is the length of that sequence.
// -----------------------------------------------------------------------------
module tb_router_input_stage;
   import router_input_stage_pkg::*;

   localparam int BUFFER_DEPTH = 4;
   localparam int XW = MAX_ROUTERS_X_WIDTH;
   localparam int YW = MAX_ROUTERS_Y_WIDTH;

   typedef struct packed {
      axis_data_t    data;
      logic          drop;
      logic [XW-1:0] tx;
      logic [YW-1:0] ty;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   axis_mosi_t    in_mosi;
   axis_miso_t    in_miso;
   axis_mosi_t    out_mosi;
   axis_miso_t    out_miso;
   logic [XW-1:0] target_x;
   logic [YW-1:0] target_y;
   logic          hdr_err;

   int            n_tests;
   int            n_fail;
   int            sent;
   axis_data_t    tx_q[$];
   exp_t          exp_q[$];
   bit            parse_in_pkt;
   logic [XW-1:0] px;
   logic [YW-1:0] py;
   bit            hold;
   bit            rand_ready;
   bit            fixed_ready;
   bit            gaps;

   always #5 clk = ~clk;

   router_input_stage #(.BUFFER_DEPTH(BUFFER_DEPTH)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .in_mosi_i  (in_mosi),
      .in_miso_o  (in_miso),
      .out_mosi_o (out_mosi),
      .out_miso_i (out_miso),
      .target_x_o (target_x),
      .target_y_o (target_y),
      .hdr_err_o  (hdr_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic axis_data_t mk_hdr(input int x, input int y, input bit last);
      axis_data_t d;
      d.TDATA = $urandom;
      d.TDATA[HDR_X_LSB +: XW] = XW'(x);
      d.TDATA[HDR_Y_LSB +: YW] = YW'(y);
      d.TLAST = last;
      d.TID   = ROUTING_HEADER;
      d.TDEST = DEST_WIDTH'($urandom);
      d.TUSER = USER_WIDTH'($urandom);
      return d;
   endfunction

   // The TID of a body beat is random, so it may equal the header marker.
   function automatic axis_data_t mk_body(input bit last);
      axis_data_t d;
      d.TDATA = $urandom;
      d.TLAST = last;
      d.TID   = ID_WIDTH'($urandom);
      d.TDEST = DEST_WIDTH'($urandom);
      d.TUSER = USER_WIDTH'($urandom);
      return d;
   endfunction

   function automatic axis_data_t mk_junk();
      axis_data_t d;
      d = mk_body($urandom_range(0, 1) == 1);
      while (d.TID == ROUTING_HEADER) d.TID = ID_WIDTH'($urandom);
      return d;
   endfunction

   task automatic classify(input axis_data_t d);
      exp_t e;
      e.data = d;
      e.drop = 1'b0;
      if (!parse_in_pkt) begin
         if (d.TID == ROUTING_HEADER) begin
            px = d.TDATA[HDR_X_LSB +: XW];
            py = d.TDATA[HDR_Y_LSB +: YW];
            parse_in_pkt = !d.TLAST;
         end else begin
            e.drop = 1'b1;
         end
      end else if (d.TLAST) begin
         parse_in_pkt = 1'b0;
      end
      e.tx = px;
      e.ty = py;
      exp_q.push_back(e);
   endtask

   // One clock cycle. Drive the inputs, compare at the falling edge, apply
   // this edge's handshakes to the reference, then step past the edge.
   task automatic tick();
      bit acc;
      if (!hold) in_mosi.TVALID = (tx_q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
      in_mosi.data    = (tx_q.size() > 0) ? tx_q[0] : '0;
      out_miso.TREADY = rand_ready ? ($urandom_range(0, 1) == 1) : fixed_ready;
      @(negedge clk);
      check("in_tready", in_miso.TREADY, exp_q.size() < BUFFER_DEPTH);
      if (exp_q.size() == 0) begin
         check("empty_valid", out_mosi.TVALID, 0);
         check("empty_err", hdr_err, 0);
      end else if (exp_q[0].drop) begin
         check("drop_valid", out_mosi.TVALID, 0);
         check("drop_err", hdr_err, 1);
         void'(exp_q.pop_front());
      end else begin
         check("beat_valid", out_mosi.TVALID, 1);
         check("beat_err", hdr_err, 0);
         check("beat_data", out_mosi.data, exp_q[0].data);
         check("beat_x", target_x, exp_q[0].tx);
         check("beat_y", target_y, exp_q[0].ty);
         if (out_miso.TREADY) void'(exp_q.pop_front());
      end
      acc = in_mosi.TVALID && in_miso.TREADY;
      if (acc) begin
         classify(tx_q.pop_front());
         sent++;
      end
      hold = in_mosi.TVALID && !acc;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic send_all(input int budget);
      int k = 0;
      while (tx_q.size() > 0 && k < budget) begin
         tick();
         k++;
      end
      check("send_budget", tx_q.size(), 0);
   endtask

   task automatic drain(input int budget);
      int k = 0;
      rand_ready  = 1'b0;
      fixed_ready = 1'b1;
      gaps        = 1'b0;
      while ((tx_q.size() > 0 || exp_q.size() > 0) && k < budget) begin
         tick();
         k++;
      end
      check("drain_budget", tx_q.size() + exp_q.size(), 0);
      tick();
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      in_mosi         = '0;
      out_miso.TREADY = 1'b0;
      hold            = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tx_q.delete();
      exp_q.delete();
      parse_in_pkt = 1'b0;
      px = '0;
      py = '0;
      @(negedge clk);
      check("rst_valid", out_mosi.TVALID, 0);
      check("rst_data", out_mosi.data, 0);
      check("rst_tready", in_miso.TREADY, 1);
      check("rst_err", hdr_err, 0);
      check("rst_x", target_x, 0);
      check("rst_y", target_y, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      axis_data_t bp_hdr;
      int         s0;
      n_tests     = 0;
      n_fail      = 0;
      sent        = 0;
      rand_ready  = 1'b0;
      fixed_ready = 1'b1;
      gaps        = 1'b0;
      out_miso    = '0;
      do_reset();

      // Single packet: header (2,1), then 3 data beats. TLAST is on the last.
      tx_q = '{mk_hdr(2, 1, 0), mk_body(0), mk_body(0), mk_body(1)};
      send_all(20);
      drain(20);

      // Stray beat in IDLE is dropped. The header after it routes normally.
      tx_q = '{mk_junk(), mk_hdr(3, 2, 0), mk_body(1)};
      send_all(20);
      drain(20);

      // Header-only packet (1,1). The stray beat after it shows the FSM
      // stayed in IDLE.
      tx_q = '{mk_hdr(1, 1, 1), mk_junk(), mk_hdr(0, 2, 1)};
      send_all(20);
      drain(20);

      // Back-to-back packets. The target switches on the second header.
      tx_q = '{mk_hdr(3, 0, 0), mk_body(1), mk_hdr(0, 3, 0), mk_body(1)};
      send_all(20);
      drain(20);

      // Backpressure: downstream stalls for 10 cycles while 6 beats are
      // offered.
      bp_hdr      = mk_hdr(1, 2, 0);
      tx_q        = '{bp_hdr, mk_body(0), mk_body(0), mk_body(0), mk_body(0), mk_body(1)};
      fixed_ready = 1'b0;
      s0          = sent;
      run(10);
      check("bp_pushes", sent - s0, 4);
      check("bp_tready", in_miso.TREADY, 0);
      check("bp_hold_data", out_mosi.data, bp_hdr);
      check("bp_hold_x", target_x, 1);
      check("bp_hold_y", target_y, 2);
      fixed_ready = 1'b1;
      send_all(40);
      drain(20);

      // Sustained throughput: 8 beats with no gaps are accepted in 8 cycles.
      tx_q = '{mk_hdr(2, 2, 0), mk_body(0), mk_body(0), mk_body(0),
               mk_body(0), mk_body(0), mk_body(0), mk_body(1)};
      s0 = sent;
      run(8);
      check("tput_pushes", sent - s0, 8);
      drain(20);

      // Reset mid-packet: 2 of 4 beats are buffered when reset hits.
      tx_q        = '{mk_hdr(2, 3, 0), mk_body(0), mk_body(0), mk_body(1)};
      fixed_ready = 1'b0;
      s0          = sent;
      run(2);
      check("rst_mid_pushes", sent - s0, 2);
      do_reset();
      tx_q = '{mk_hdr(3, 3, 0), mk_body(1)};
      send_all(20);
      drain(20);

      // Random packets, with stray beats, input gaps and random downstream
      // ready.
      for (int p = 0; p < 60; p++) begin
         int len;
         if ($urandom_range(0, 4) == 0) tx_q.push_back(mk_junk());
         len = $urandom_range(1, 4);
         tx_q.push_back(mk_hdr($urandom_range(0, MAX_ROUTERS_X - 1),
                               $urandom_range(0, MAX_ROUTERS_Y - 1), len == 1));
         for (int b = 1; b < len; b++) tx_q.push_back(mk_body(b == len - 1));
      end
      rand_ready = 1'b1;
      gaps       = 1'b1;
      send_all(5000);
      drain(100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/router_input_stage.md
# router_input_stage

Per-port ingress stage of the AXI-Stream mesh router: buffers incoming flits in a small FIFO, decodes the routing header, and presents each packet beat to the `algorithm` channel selector. While a packet is in flight it holds the target coordinates stable, so the selector keeps steering every beat to the same output until TLAST. There is one instance per router input channel, directly upstream of `algorithm`.

## Interface
Parameters:
- `DATA_WIDTH`, 32: TDATA width, passed through the `axis_mosi_t` payload.
- `ID_WIDTH` / `DEST_WIDTH` / `USER_WIDTH`, 4: present under the same `TID_PRESENT` / `TDEST_PRESENT` / `TUSER_PRESENT` defines as the rest of the router.
- `BUFFER_DEPTH`, 4: FIFO entries. Power of two, ≥2.
- `MAX_ROUTERS_X`, 4: mesh width. `MAX_ROUTERS_X_WIDTH` = $clog2 of it.
- `MAX_ROUTERS_Y`, 4: mesh height. `MAX_ROUTERS_Y_WIDTH` = $clog2 of it.

Ports:
- `clk_i`  in  1  sole clock.
- `rst_i`  in  1  **synchronous, active-high** reset.
- `in_mosi_i`  in  `axis_mosi_t`  flits from the link or local port.
- `in_miso_o`  out  `axis_miso_t`  TREADY back to the sender.
- `out_mosi_o`  out  `axis_mosi_t`  head beat to `algorithm`.
- `out_miso_i`  in  `axis_miso_t`  TREADY from `algorithm`.
- `target_x_o`  out  `MAX_ROUTERS_X_WIDTH`  destination X for the current beat.
- `target_y_o`  out  `MAX_ROUTERS_Y_WIDTH`  destination Y for the current beat.
- `hdr_err_o`  out  1  one-cycle pulse when a beat is dropped for a protocol violation.

## Operation
- **Header beat**: TID == `ROUTING_HEADER`.
  - TDATA[MAX_ROUTERS_X_WIDTH-1:0] carries X.
  - TDATA[MAX_ROUTERS_X_WIDTH +: MAX_ROUTERS_Y_WIDTH] carries Y.
- **Ingress**:
  - `in_miso_o.TREADY` = !full.
  - A push occurs when TVALID && TREADY; the whole `axis_mosi_t.data` is stored.
- **Egress**:
  - `out_mosi_o.data` = FIFO head.
  - `out_mosi_o.TVALID` = !empty, except while dropping (below).
  - A pop occurs when TVALID && `out_miso_i.TREADY`.
- **FSM states**: `IDLE` (expecting a header) and `PACKET`.
  - `IDLE`, head is a header:
    - target_x_o/target_y_o are decoded combinationally from the head.
    - On pop, latch X/Y into `route_q`.
    - Go to `PACKET` unless the header also has TLAST, in which case stay in `IDLE`.
  - `IDLE`, head is not a header (protocol error):
    - Force `out_mosi_o.TVALID` = 0.
    - Pop the beat internally regardless of `out_miso_i`.
    - Pulse `hdr_err_o`; stay in `IDLE`.
  - `PACKET`:
    - target_x_o/target_y_o = `route_q`.
    - A beat with TID == `ROUTING_HEADER` is forwarded as ordinary data.
    - Pop of a TLAST beat returns to `IDLE`.
- **Stability**: target outputs never change while `out_mosi_o.TVALID` is high and the beat is not yet accepted. The AXIS rule that payload is held until handshake applies here too.
- **Pointers**: read and write pointers are $clog2(BUFFER_DEPTH)+1 bits, with an MSB wrap bit.
  - full = MSBs differ and the low bits are equal.
  - empty = the pointers are equal.

## Timing
- **Latency**: a beat pushed at edge N appears on `out_mosi_o` after edge N. There is no same-cycle bypass.
- **Throughput**: 1 beat/cycle sustained when downstream is always ready.
- **Simultaneous push and pop**:
  - Allowed whenever not full; occupancy is unchanged.
  - When full, TREADY = 0, so there is no push even if a pop happens that cycle. This registered-ready style costs one bubble after full.
- **Reset**, applied at the next rising edge while `rst_i` = 1:
  - Pointers are cleared, the FSM goes to `IDLE`, and `route_q` = 0.
  - `out_mosi_o` = '0 and `hdr_err_o` = 0. `in_miso_o.TREADY` = 1 once reset is released.
  - Reset mid-packet discards all buffered beats; no partial-packet recovery.
- `hdr_err_o` is asserted in the same cycle as the dropped beat's internal pop.

## Structure
- **Shared router package**:
  - `axis_mosi_t` / `axis_miso_t` stay as currently defined.
  - `ROUTING_HEADER` constant.
  - New `route_state_e` enum (`IDLE`, `PACKET`).
  - Header field-offset localparams `HDR_X_LSB` and `HDR_Y_LSB`.
- **Sub-module**: `axis_fifo` (generic depth/type FIFO: push/pop, full/empty). It is reusable by the output-side buffers.
- **Top level**: `router_input_stage` holds the FSM, `route_q`, the drop logic and the target mux.

## Test plan
- **Single packet**: push a header (X=2, Y=1), 3 data beats, TLAST on the last, downstream always ready. Expect:
  - 4 beats out in order, first out 1 cycle after the first push.
  - Target outputs 2/1 on all 4 beats.
  - FSM back in `IDLE` after the TLAST pop.
- **Backpressure**: `out_miso_i.TREADY` = 0 for 10 cycles while 6 beats are offered at depth 4. Expect:
  - `in_miso_o.TREADY` drops after 4 pushes.
  - Output beat and targets held constant.
  - All 6 beats delivered after release, no loss or duplication.
- **Back-to-back packets**: headers with (X=3, Y=0) then (X=0, Y=3), 2 beats each, no gap. Expect targets to switch exactly on the second header beat.
- **Protocol error**: a data beat (TID ≠ `ROUTING_HEADER`) arrives in `IDLE`. Expect:
  - `hdr_err_o` = 1 for one cycle, and that beat never shows TVALID on `out_mosi_o`.
  - The following header is routed normally.
- **Header-only packet**: header with TLAST, target (X=1, Y=1). Expect one beat out with targets 1/1 and FSM staying in `IDLE`.
- **Reset mid-packet**: assert `rst_i` after 2 of 4 beats are pushed. Expect:
  - After the next edge, `out_mosi_o.TVALID` = 0, FIFO empty, targets 0.
  - A new header is accepted cleanly afterwards.
